// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int unsigned REG_W                 = 5;
  localparam int unsigned DEF_CNT_W             = 2;
  localparam int unsigned DEF_LOAD_BRANCH_STALL = 2;
  localparam int unsigned DEF_STAT_W            = 16;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Pipeline-side signal bundle of the hazard sequencer; HAZARD_STATS_EN adds the stats outputs.
interface pipeline_hazard_sequencer_if
`ifdef HAZARD_STATS_EN
  #(parameter int unsigned STAT_W = hazard_pkg::DEF_STAT_W)
`endif
  ;
  import hazard_pkg::*;

  logic [REG_W-1:0] IF_ID_Rs;
  logic [REG_W-1:0] IF_ID_Rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             id_jr;
  logic             id_jump;
  logic             branch_taken;
  logic [REG_W-1:0] ID_EX_Rd;
  logic             ID_EX_RegWrite;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] EX_MEM_Rd;
  logic             EX_MEM_MemRead;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ControlZero;
  logic             stalling;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] flush_count;
`endif

  modport master (
    output IF_ID_Rs, IF_ID_Rt, id_uses_rt, id_branch, id_jr, id_jump, branch_taken,
           ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_Rd, EX_MEM_MemRead,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ControlZero, stalling
`ifdef HAZARD_STATS_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, id_uses_rt, id_branch, id_jr, id_jump, branch_taken,
           ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_Rd, EX_MEM_MemRead,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ControlZero, stalling
`ifdef HAZARD_STATS_EN
    , output stall_cycles, flush_count
`endif
  );

endinterface

// File: rtl/hazard_reg_match.sv
// Matches one producer destination against the ID instruction's source registers.
module hazard_reg_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rd,
  input  logic             en,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rt_read,
  output logic             hit
);

  // $zero is never a real dependency
  assign hit = en && (rd != REG_ZERO) && ((rd == rs) || (rt_read && (rd == rt)));

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush controller for a 5-stage pipeline with ID-resolved branches and jr.
// Optional saturating statistics counters under HAZARD_STATS_EN.
module pipeline_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W             = DEF_CNT_W,
  parameter int unsigned LOAD_BRANCH_STALL = DEF_LOAD_BRANCH_STALL,
  parameter int unsigned STAT_W            = DEF_STAT_W
) (
  input logic                        Clk,
  input logic                        Rst,
  pipeline_hazard_sequencer_if.slave bus
);

  if ((LOAD_BRANCH_STALL == 0) || (LOAD_BRANCH_STALL > ((2 ** CNT_W) - 1))) begin : g_bad_lbs
    $error("LOAD_BRANCH_STALL must be in 1..2^CNT_W-1");
  end
  if (STAT_W == 0) begin : g_bad_stat_w
    $error("STAT_W must be non-zero");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   need;
  logic               rt_read, id_consumer, redirect;
  logic               ex_ld_hit, ex_alu_hit, mem_ld_hit;
  logic               pc_write, if_id_write, if_id_flush, control_zero, stalling;

  assign rt_read     = bus.id_uses_rt | bus.id_branch;
  assign id_consumer = bus.id_branch | bus.id_jr;
  assign redirect    = bus.id_jump | bus.id_jr | (bus.id_branch & bus.branch_taken);

  hazard_reg_match u_ex_ld (
    .rd(bus.ID_EX_Rd), .en(bus.ID_EX_MemRead),
    .rs(bus.IF_ID_Rs), .rt(bus.IF_ID_Rt), .rt_read(rt_read), .hit(ex_ld_hit)
  );
  hazard_reg_match u_ex_alu (
    .rd(bus.ID_EX_Rd), .en(bus.ID_EX_RegWrite & ~bus.ID_EX_MemRead),
    .rs(bus.IF_ID_Rs), .rt(bus.IF_ID_Rt), .rt_read(rt_read), .hit(ex_alu_hit)
  );
  hazard_reg_match u_mem_ld (
    .rd(bus.EX_MEM_Rd), .en(bus.EX_MEM_MemRead),
    .rs(bus.IF_ID_Rs), .rt(bus.IF_ID_Rt), .rt_read(rt_read), .hit(mem_ld_hit)
  );

  // Required bubbles; the load-in-EX term always dominates the single-bubble terms
  always_comb begin
    need = '0;
    if ((ex_alu_hit | mem_ld_hit) & id_consumer) need = CNT_W'(1);
    if (ex_ld_hit) need = id_consumer ? CNT_W'(LOAD_BRANCH_STALL) : CNT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    control_zero = 1'b0;
    stalling     = 1'b0;
    if (Rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      control_zero = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (need != '0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            control_zero = 1'b1;
            cnt_d        = need - CNT_W'(1);
            state_d      = (cnt_d != '0) ? STALL : RUN;
          end else if (redirect) begin
            if_id_flush = 1'b1;
          end
        end
        STALL: begin
          // Hazard inputs are ignored here; the counter alone ends the stall
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          control_zero = 1'b1;
          stalling     = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IF_ID_Write = if_id_write;
  assign bus.IF_ID_Flush = if_id_flush;
  assign bus.ControlZero = control_zero;
  assign bus.stalling    = stalling;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [STAT_W-1:0] flush_count_q, flush_count_d;

  // Saturating event counters, idle while reset is held
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!Rst && !pc_write && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + STAT_W'(1);
    if (!Rst && if_id_flush && !(&flush_count_q)) flush_count_d = flush_count_q + STAT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule
